serial_chunk_adder: RTL and testbench
=====================================

# serial_chunk_adder

- Parametrised multi-cycle adder/subtractor: adds WIDTH-bit operands CHUNK bits per clock, LSB chunk first.
- Uses a start/busy/done handshake and a registered result with carry-out and signed-overflow flags.
- Result bus is gated by an output enable, tri-stated when the feature below is compiled in.
- Successor to the combinational 32-bit enabled adder; sits on shared datapath buses where area matters more than single-cycle latency.

## Interface
- WIDTH, 32, operand/result width; must be a positive multiple of CHUNK
- CHUNK, 8, bits added per cycle; N = WIDTH/CHUNK cycles per operation
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted when not busy
- sub  input  1  0: a+b+cin; 1: a-b (cin ignored); sampled with start
- cin  input  1  carry-in for add; sampled with start
- a  input  WIDTH  operand, sampled with start
- b  input  WIDTH  operand, sampled with start
- out_en  input  1  drive enable for Z (combinational gate)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, result valid
- Z  output  WIDTH  result bus
- cout  output  1  carry out of MSB (sub: 1 = no borrow)
- ovf  output  1  two's-complement overflow

## Operation
- States: IDLE, RUN, DONE.
  - IDLE/DONE, start=1: latch a, b^{WIDTH{sub}}, carry = sub ? 1 : cin; clear chunk counter; go RUN.
  - DONE, start=0: go IDLE.
  - RUN: add chunk k of latched operands plus stored carry; write sum into partial register slice k; store chunk carry; k++. After chunk N-1, go DONE.
- On entering DONE, in the same edge:
  - copy the full partial sum to the result register;
  - cout = final carry;
  - ovf = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]), where b' is the inverted b for sub.
- Result register, cout and ovf hold until the next completion. They are not disturbed during RUN.
- start while busy is ignored; operands are not re-sampled.
- done is high exactly in the DONE cycle. A start in that cycle is accepted, giving back-to-back operation.
- Z = out_en ? result : idle value (see Configuration). cout/ovf are always driven.
- Arithmetic is modulo 2^WIDTH; chunk adds are CHUNK+1 bits wide.

## Timing
- Reset (async, immediate): state IDLE, busy=0, done=0, result=0, cout=0, ovf=0, counter=0. Z = idle value if out_en=0, else 0.
- Start sampled at edge E:
  - busy=1 from E to E+N;
  - chunks processed at edges E+1..E+N;
  - done=1, busy=0, new Z/cout/ovf valid after edge E+N;
  - latency N cycles.
- Throughput: one operation per N+1 cycles with back-to-back start.
- Reset asserted mid-RUN: operation abandoned, all outputs return to reset values, no done pulse. After reset release, the next start behaves normally.
- N=1 (CHUNK=WIDTH): a single RUN cycle; the rules above still hold.
- out_en → Z is combinational, zero-cycle.

## Configuration
- SERIAL_CHUNK_ADDER_TRISTATE_EN defined: Z is 'z on all bits when out_en=0, for a shared bus.
- Undefined: Z is driven to 0 when out_en=0; no tri-state logic is inferred.
- All other behaviour is identical in both builds.

## Test plan
All with WIDTH=32, CHUNK=8 (N=4), TRISTATE defined.
- Wrap with carry: start with a=32'hFFFFFFFF, b=1, cin=0, sub=0, out_en=1 → done 4 cycles after the start edge; Z=0, cout=1, ovf=0; busy high exactly 4 cycles.
- Signed overflow: a=32'h7FFFFFFF, b=1 → Z=32'h80000000, ovf=1, cout=0. Subtract: a=5, b=7, sub=1 → Z=32'hFFFFFFFE, cout=0.
- Back-to-back with ignored start: start every cycle with a fresh random a, b → only starts in IDLE/DONE are accepted; each Z equals the sampled a+b+cin; operands presented while busy have no effect.
- Mid-operation reset: assert rst 2 cycles into RUN → busy, done, cout, ovf drop immediately; Z=0; no done pulse; the next op (a=3, b=4) gives Z=7.
- Output gating: out_en=0 → Z=32'hZZZZZZZZ while result is retained. Raise out_en → prior result appears the same cycle. Rebuild without the macro → Z=0 when out_en=0.
- Random regression: 1000 random a/b/sub/cin ops, also at CHUNK=1 and CHUNK=32 → Z, cout and ovf match the reference model.

Source files
------------

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: multi-cycle add/sub, CHUNK bits per clock, LSB chunk first.
// Optional macro SERIAL_CHUNK_ADDER_TRISTATE_EN: Z floats when out_en=0 (else driven 0).
// Ports: clk, rst (async, active-high), start/sub/cin/a/b (request, sampled on start),
//        out_en (Z gate), busy, done (1-cycle pulse), Z (result), cout, ovf.
module serial_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             out_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Z,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;

    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] part_nxt;

    // Operands shift right each chunk so the low CHUNK bits are always the
    // current chunk; sums enter the partial register from the top, so after
    // N chunks the partial register holds the full sum in place.
    assign sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
               + (CHUNK+1)'(c_q);
    assign part_nxt = (part_q >> CHUNK)
                    | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        case (state_q)
            S_RUN: begin
                a_d    = a_q >> CHUNK;
                b_d    = b_q >> CHUNK;
                c_d    = sum[CHUNK];
                part_d = part_nxt;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    res_d   = part_nxt;
                    cout_d  = sum[CHUNK];
                    ovf_d   = (amsb_q == bmsb_q)
                           && (part_nxt[WIDTH-1] != amsb_q);
                end
            end
            default: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    c_d     = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    part_d  = '0;
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1] ^ sub;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            part_q  <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign cout = cout_q;
    assign ovf  = ovf_q;

`ifdef SERIAL_CHUNK_ADDER_TRISTATE_EN
    assign Z = out_en ? res_q : {WIDTH{1'bz}};
`else
    assign Z = out_en ? res_q : '0;
`endif

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb_serial_chunk_adder: directed and random checks of serial_chunk_adder
// at CHUNK=8 (main), CHUNK=1 and CHUNK=32, all WIDTH=32.
module tb_serial_chunk_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_en = 1'b1;

    logic        busy0, done0, cout0, ovf0;
    logic [31:0] z0;
    logic        busy1, done1, cout1, ovf1;
    logic [31:0] z1;
    logic        busy2, done2, cout2, ovf2;
    logic [31:0] z2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut0 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .out_en(out_en), .busy(busy0), .done(done0),
        .Z(z0), .cout(cout0), .ovf(ovf0));

    serial_chunk_adder #(.WIDTH(32), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .out_en(out_en), .busy(busy1), .done(done1),
        .Z(z1), .cout(cout1), .ovf(ovf1));

    serial_chunk_adder #(.WIDTH(32), .CHUNK(32)) dut2 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .out_en(out_en), .busy(busy2), .done(done2),
        .Z(z2), .cout(cout2), .ovf(ovf2));

    function automatic logic idle_ok(input logic [31:0] z);
`ifdef SERIAL_CHUNK_ADDER_TRISTATE_EN
        return (z === 32'hzzzzzzzz) || (z === 32'h0);
`else
        return (z === 32'h0);
`endif
    endfunction

    // Drive one request at a negedge; measure busy cycles and done latency
    // (edges after the start edge) on the CHUNK=8 instance.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_,
                          input logic ts, input logic tc,
                          output int bcyc, output int lat);
        @(negedge clk);
        a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bcyc = 0;
        lat  = -1;
        for (int k = 0; k < 50; k++) begin
            if (busy0) bcyc++;
            if (done0) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1;
        n_tests++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || cout0 !== 1'b0 || ovf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b done=%b cout=%b ovf=%b, need 0000",
                     busy0, done0, cout0, ovf0);
        end
        n_tests++;
        if (z0 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_z: Z=%h, need 0", z0);
        end
        out_en = 1'b0;
        #1;
        n_tests++;
        if (!idle_ok(z0)) begin
            n_fail++;
            $display("FAIL reset_z_idle: Z=%h, need idle value", z0);
        end
        out_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wrap;
        int bc, lat;
        run_op(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, bc, lat);
        n_tests++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL wrap_latency: got %0d, need 4", lat);
        end
        n_tests++;
        if (bc !== 4) begin
            n_fail++;
            $display("FAIL wrap_busy_cycles: got %0d, need 4", bc);
        end
        n_tests++;
        if (z0 !== 32'h0 || cout0 !== 1'b1 || ovf0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_result: Z=%h cout=%b ovf=%b busy=%b, need 0 1 0 0",
                     z0, cout0, ovf0, busy0);
        end
    endtask

    task automatic test_overflow;
        int bc, lat;
        run_op(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, bc, lat);
        n_tests++;
        if (z0 !== 32'h80000000 || cout0 !== 1'b0 || ovf0 !== 1'b1 || lat !== 4) begin
            n_fail++;
            $display("FAIL ovf_add: Z=%h cout=%b ovf=%b lat=%0d, need 80000000 0 1 4",
                     z0, cout0, ovf0, lat);
        end
        run_op(32'd5, 32'd7, 1'b1, 1'b1, bc, lat);
        n_tests++;
        if (z0 !== 32'hFFFFFFFE || cout0 !== 1'b0 || ovf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_5_7: Z=%h cout=%b ovf=%b, need FFFFFFFE 0 0",
                     z0, cout0, ovf0);
        end
        run_op(32'h80000000, 32'h1, 1'b1, 1'b0, bc, lat);
        n_tests++;
        if (z0 !== 32'h7FFFFFFF || cout0 !== 1'b1 || ovf0 !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_ovf: Z=%h cout=%b ovf=%b, need 7FFFFFFF 1 1",
                     z0, cout0, ovf0);
        end
        run_op(32'h10, 32'h20, 1'b0, 1'b1, bc, lat);
        n_tests++;
        if (z0 !== 32'h31 || cout0 !== 1'b0 || ovf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL add_cin: Z=%h cout=%b ovf=%b, need 31 0 0",
                     z0, cout0, ovf0);
        end
    endtask

    // Start held high with fresh operands every cycle; only starts at
    // cycles 0,5,10,15 land in IDLE/DONE and are accepted.
    task automatic test_back_to_back;
        logic [31:0] exp_q[$];
        logic [31:0] ra, rb;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            if (c > 0) begin
                n_tests++;
                if (c % 5 == 0) begin
                    if (done0 !== 1'b1 || busy0 !== 1'b0 || z0 !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL b2b_done c=%0d: done=%b busy=%b Z=%h, need 1 0 %h",
                                 c, done0, busy0, z0, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end else if (done0 !== 1'b0 || busy0 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_busy c=%0d: done=%b busy=%b, need 0 1",
                             c, done0, busy0);
                end
            end
            if (c < 20) begin
                ra = $urandom;
                rb = $urandom;
                a = ra; b = rb; sub = 1'b0; cin = c[0]; start = 1'b1;
                if (c % 5 == 0) exp_q.push_back(ra + rb + {31'd0, c[0]});
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        int bc, lat;
        run_op(32'h80000000, 32'h80000001, 1'b0, 1'b0, bc, lat);
        n_tests++;
        if (z0 !== 32'h1 || cout0 !== 1'b1 || ovf0 !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_op: Z=%h cout=%b ovf=%b, need 1 1 1",
                     z0, cout0, ovf0);
        end
        @(negedge clk);
        a = 32'h1234; b = 32'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || cout0 !== 1'b0
            || ovf0 !== 1'b0 || z0 !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b done=%b cout=%b ovf=%b Z=%h, need 0 0 0 0 0",
                     busy0, done0, cout0, ovf0, z0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tests++;
            if (done0 !== 1'b0 || busy0 !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_quiet k=%0d: done=%b busy=%b, need 0 0",
                         k, done0, busy0);
            end
        end
        run_op(32'd3, 32'd4, 1'b0, 1'b0, bc, lat);
        n_tests++;
        if (z0 !== 32'd7 || lat !== 4) begin
            n_fail++;
            $display("FAIL post_reset_op: Z=%h lat=%0d, need 7 4", z0, lat);
        end
    endtask

    task automatic test_gating;
        @(negedge clk);
        out_en = 1'b0;
        #1;
        n_tests++;
        if (!idle_ok(z0) || z0 === 32'd7) begin
            n_fail++;
            $display("FAIL gate_off: Z=%h, need idle value", z0);
        end
        n_tests++;
        if (cout0 !== 1'b0 || ovf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_flags: cout=%b ovf=%b, need 0 0", cout0, ovf0);
        end
        @(negedge clk);
        @(negedge clk);
        out_en = 1'b1;
        #1;
        n_tests++;
        if (z0 !== 32'd7) begin
            n_fail++;
            $display("FAIL gate_on: Z=%h, need 7", z0);
        end
    endtask

    task automatic test_random;
        logic [31:0] ra, rb, bb, ez;
        logic        rs, rc, ec, eo;
        logic [32:0] full;
        logic [2:0]  got;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            bb   = rs ? ~rb : rb;
            full = {1'b0, ra} + {1'b0, bb} + {32'd0, rs ? 1'b1 : rc};
            ez   = full[31:0];
            ec   = full[32];
            eo   = (ra[31] == bb[31]) && (ez[31] != ra[31]);
            @(negedge clk);
            a = ra; b = rb; sub = rs; cin = rc; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            got = 3'b000;
            for (int k = 0; k < 40 && got != 3'b111; k++) begin
                if (done0) got[0] = 1'b1;
                if (done1) got[1] = 1'b1;
                if (done2) got[2] = 1'b1;
                if (got != 3'b111) @(negedge clk);
            end
            n_tests++;
            if (got != 3'b111) begin
                n_fail++;
                $display("FAIL rand_timeout op %0d: done seen %b, need 111", i, got);
            end
            n_tests++;
            if (z0 !== ez || cout0 !== ec || ovf0 !== eo) begin
                n_fail++;
                $display("FAIL rand_c8 op %0d: Z=%h c=%b v=%b, need %h %b %b",
                         i, z0, cout0, ovf0, ez, ec, eo);
            end
            n_tests++;
            if (z1 !== ez || cout1 !== ec || ovf1 !== eo) begin
                n_fail++;
                $display("FAIL rand_c1 op %0d: Z=%h c=%b v=%b, need %h %b %b",
                         i, z1, cout1, ovf1, ez, ec, eo);
            end
            n_tests++;
            if (z2 !== ez || cout2 !== ec || ovf2 !== eo) begin
                n_fail++;
                $display("FAIL rand_c32 op %0d: Z=%h c=%b v=%b, need %h %b %b",
                         i, z2, cout2, ovf2, ez, ec, eo);
            end
        end
    endtask

    initial begin
        test_reset;
        test_wrap;
        test_overflow;
        test_back_to_back;
        test_mid_reset;
        test_gating;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
